// File: rtl/texmem_pkg.sv
// Shared widths, per-channel FSM encoding and the bus write-window check
// for the multi-channel texture memory.
package texmem_pkg;

    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
    localparam int WORDS_PER_ROW   = 4;
    localparam int ADDR_W          = 27;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RD   = 2'd1,
        CH_RSP  = 2'd2
    } ch_state_t;

    // One extra bit on the offset so a window touching the top of the
    // address space cannot wrap into a false hit.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W:0]   size);
        logic [ADDR_W:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < size);
    endfunction

endpackage

// File: rtl/texmem_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last
// granted channel; the pointer moves only when something is granted.
module texmem_rr_arbiter
#(
    parameter int  NUM_CH = 2,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx
);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] idx;
    logic            any;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any      = 1'b1;
            end
        end
    end

    // Reset to the last channel so channel 0 wins the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= CH_W'(NUM_CH - 1);
        end else if (any) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/texture_memory_mc.sv
// Multi-channel texture memory: bus-written 32-bit lanes, 256-bit block reads
// served to NUM_CH valid/ready channels. Optional TEXMEM_WRITE_FORWARD_EN.
module texture_memory_mc
    import texmem_pkg::*;
#(
    parameter int          NUM_CH       = 2,
    parameter int          TEX_COUNT    = 128,
    parameter int          ROWS_PER_TEX = 16,
    parameter logic [26:0] WIN_BASE     = 27'h0002000,
    localparam int         TEX_IDX_W    = $clog2(TEX_COUNT),
    localparam int         ROW_IDX_W    = $clog2(ROWS_PER_TEX)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_wea,
    input  logic [26:0]                 i_waddr,
    input  logic [31:0]                 i_wdata,
    output logic                        o_werr,
    input  logic [NUM_CH-1:0]           i_req_valid,
    output logic [NUM_CH-1:0]           o_req_ready,
    input  logic [NUM_CH*TEX_IDX_W-1:0] i_tex_idx,
    input  logic [NUM_CH*ROW_IDX_W-1:0] i_row_idx,
    output logic [NUM_CH-1:0]           o_rsp_valid,
    input  logic [NUM_CH-1:0]           i_rsp_ready,
    output logic [NUM_CH*BLOCK_W-1:0]   o_rsp_data,
    output logic [NUM_CH-1:0]           o_rsp_row_sel
);

    localparam int DEPTH_BLOCKS = TEX_COUNT * ROWS_PER_TEX / 2;
    localparam int BLK_AW       = $clog2(DEPTH_BLOCKS);
    localparam int WIN_BYTES    = DEPTH_BLOCKS * (BLOCK_W / 8);
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Handshakes: a request transfers in a cycle where i_req_valid and
    // o_req_ready are both high; a response transfers in a cycle where
    // o_rsp_valid and i_rsp_ready are both high. Payloads hold while valid.

    logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] mem [DEPTH_BLOCKS];

    logic [ADDR_W-1:0] wr_off;
    logic              wr_en;
    logic [BLK_AW-1:0] wr_blk;
    logic [2:0]        wr_lane;

    assign wr_off  = i_waddr - WIN_BASE;
    assign wr_en   = i_wea & in_window(i_waddr, WIN_BASE, (ADDR_W+1)'(WIN_BYTES));
    assign wr_blk  = BLK_AW'(wr_off >> 5);
    assign wr_lane = 3'(wr_off >> 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_werr <= 1'b0;
        end else begin
            o_werr <= i_wea & ~wr_en;
        end
    end

    ch_state_t         ch_state [NUM_CH];
    logic [BLK_AW-1:0] ch_blk   [NUM_CH];
    logic [NUM_CH-1:0] ch_row_lsb;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;

    // Two consecutive rows share one block, so the row LSB only selects a half.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_blk[c] = BLK_AW'({i_tex_idx[c*TEX_IDX_W +: TEX_IDX_W],
                                 i_row_idx[c*ROW_IDX_W +: ROW_IDX_W]} >> 1);
            ch_row_lsb[c] = i_row_idx[c*ROW_IDX_W];
            eligible[c]   = i_req_valid[c] && (ch_state[c] == CH_IDLE);
        end
    end

    texmem_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (eligible),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign o_req_ready = gnt;

    logic [BLK_AW-1:0]  rd_addr;
    logic [BLOCK_W-1:0] rd_raw;
    logic [BLOCK_W-1:0] rd_data;
    logic               rd_row_sel_q;

    assign rd_addr = ch_blk[gnt_idx];

    // Read-first RAM; only one channel can be in RD at a time, so one
    // shared read register carries the block through to the response.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_blk][wr_lane] <= i_wdata;
        end
        rd_raw       <= mem[rd_addr];
        rd_row_sel_q <= ch_row_lsb[gnt_idx];
    end

`ifdef TEXMEM_WRITE_FORWARD_EN
    logic              fwd_hit_q;
    logic [2:0]        fwd_lane_q;
    logic [WORD_W-1:0] fwd_data_q;
    logic [BLK_AW-1:0] rd_blk_q;

    always_ff @(posedge clk) begin
        rd_blk_q   <= rd_addr;
        fwd_hit_q  <= wr_en && (|gnt) && (wr_blk == rd_addr);
        fwd_lane_q <= wr_lane;
        fwd_data_q <= i_wdata;
    end

    // Accept-cycle write first, then the RD-cycle write, so the later one wins.
    always_comb begin
        rd_data = rd_raw;
        if (fwd_hit_q) begin
            rd_data[fwd_lane_q*WORD_W +: WORD_W] = fwd_data_q;
        end
        if (wr_en && (wr_blk == rd_blk_q)) begin
            rd_data[wr_lane*WORD_W +: WORD_W] = i_wdata;
        end
    end
`else
    assign rd_data = rd_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ch_state[c] <= CH_IDLE;
            end
            o_rsp_valid   <= '0;
            o_rsp_data    <= '0;
            o_rsp_row_sel <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (ch_state[c])
                    CH_IDLE: begin
                        if (gnt[c]) begin
                            ch_state[c] <= CH_RD;
                        end
                    end
                    CH_RD: begin
                        ch_state[c]                      <= CH_RSP;
                        o_rsp_valid[c]                   <= 1'b1;
                        o_rsp_data[c*BLOCK_W +: BLOCK_W] <= rd_data;
                        o_rsp_row_sel[c]                 <= rd_row_sel_q;
                    end
                    CH_RSP: begin
                        if (i_rsp_ready[c]) begin
                            ch_state[c]    <= CH_IDLE;
                            o_rsp_valid[c] <= 1'b0;
                        end
                    end
                    default: ch_state[c] <= CH_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_texture_memory_mc.sv
// Bench for texture_memory_mc: write-window table, fetch table and corner
// sequences, with a per-channel expected-response queue fed by a RAM model.
module tb_texture_memory_mc;

    localparam int          NUM_CH    = 2;
    localparam int          TW        = 7;
    localparam int          RW        = 4;
    localparam int          DEPTH     = 1024;
    localparam int          WIN_BYTES = 32'h8000;
    localparam logic [26:0] WIN_BASE  = 27'h0002000;

    typedef struct {
        logic [26:0] addr;
        logic [31:0] data;
        logic        exp_werr;
    } wr_vec_t;

    typedef struct {
        int ch;
        int tex;
        int row;
    } rd_vec_t;

    logic                  clk;
    logic                  rst_n;
    logic                  wea;
    logic [26:0]           waddr;
    logic [31:0]           wdata;
    logic                  werr;
    logic [NUM_CH-1:0]     req_valid;
    logic [NUM_CH-1:0]     req_ready;
    logic [NUM_CH*TW-1:0]  tex_idx;
    logic [NUM_CH*RW-1:0]  row_idx;
    logic [NUM_CH-1:0]     rsp_valid;
    logic [NUM_CH-1:0]     rsp_ready;
    logic [NUM_CH*256-1:0] rsp_data;
    logic [NUM_CH-1:0]     rsp_row_sel;

    texture_memory_mc #(
        .NUM_CH       (NUM_CH),
        .TEX_COUNT    (128),
        .ROWS_PER_TEX (16),
        .WIN_BASE     (WIN_BASE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wea         (wea),
        .i_waddr       (waddr),
        .i_wdata       (wdata),
        .o_werr        (werr),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_tex_idx     (tex_idx),
        .i_row_idx     (row_idx),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_data    (rsp_data),
        .o_rsp_row_sel (rsp_row_sel)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] model [DEPTH*8];
    logic [256:0] exp_q [NUM_CH][$];
    bit          pend     [NUM_CH];
    int          gcyc     [NUM_CH];
    int          pend_blk [NUM_CH];
    bit          granted  [NUM_CH];
    int          gnt_log [$];
    bit          log_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] model_block(input int blk);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = model[blk*8 + k];
        return v;
    endfunction

    function automatic bit bench_in_win(input logic [26:0] a);
        return (int'(a) >= int'(WIN_BASE)) && (int'(a) < int'(WIN_BASE) + WIN_BYTES);
    endfunction

    function automatic logic [26:0] word_addr(input int word);
        return 27'(int'(WIN_BASE) + word*4);
    endfunction

    // Compare DUT outputs for the current cycle against the expected queues.
    task automatic observe();
        logic [256:0] e;
        int           blk;
        if ($countones(req_valid) > 1) chk("grant_onehot", 256'($countones(req_ready) <= 1), 256'(1));
        for (int c = 0; c < NUM_CH; c++) begin
            granted[c] = 1'b0;
            if (exp_q[c].size() != 0) chk("ready_while_busy", 256'(req_ready[c]), 256'(0));
            if (rsp_valid[c]) begin
                if (exp_q[c].size() == 0) begin
                    chk("spurious_rsp", 256'(rsp_valid[c]), 256'(0));
                end else begin
                    if (pend[c]) begin
                        chk("latency", 256'(cyc - gcyc[c]), 256'(2));
                        pend[c] = 1'b0;
                    end
                    e = exp_q[c][0];
                    chk("rsp_data", rsp_data[c*256 +: 256], e[255:0]);
                    chk("rsp_row_sel", 256'(rsp_row_sel[c]), 256'(e[256]));
                    if (rsp_ready[c]) void'(exp_q[c].pop_front());
                end
            end
            if (req_valid[c] && req_ready[c]) begin
                blk = int'(tex_idx[c*TW +: TW]) * 8 + int'(row_idx[c*RW +: RW]) / 2;
                exp_q[c].push_back({row_idx[c*RW], model_block(blk)});
                pend[c]     = 1'b1;
                gcyc[c]     = cyc;
                pend_blk[c] = blk;
                granted[c]  = 1'b1;
                if (log_en) gnt_log.push_back(c);
            end
        end
    endtask

    // One cycle: check, apply the bus write to the model, advance the clock.
    task automatic tick();
        int           w;
        logic [256:0] e;
        #1;
        observe();
        if (wea && bench_in_win(waddr)) begin
            w = (int'(waddr) - int'(WIN_BASE)) >> 2;
`ifdef TEXMEM_WRITE_FORWARD_EN
            for (int c = 0; c < NUM_CH; c++) begin
                if (pend[c] && (cyc - gcyc[c] <= 1) && (pend_blk[c] == w / 8) && exp_q[c].size() != 0) begin
                    e = exp_q[c].pop_back();
                    e[32*(w % 8) +: 32] = wdata;
                    exp_q[c].push_back(e);
                end
            end
`else
            e = '0;
`endif
            model[w] = wdata;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int ch, input int tex, input int row);
        tex_idx[ch*TW +: TW] = TW'(tex);
        row_idx[ch*RW +: RW] = RW'(row);
    endtask

    task automatic bus_write(input logic [26:0] a, input logic [31:0] d);
        wea   = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        wea   = 1'b0;
    endtask

    task automatic run_fetch(input int ch, input int tex, input int row, output int waited);
        waited        = 0;
        req_valid[ch] = 1'b1;
        set_req(ch, tex, row);
        tick();
        while (!granted[ch] && waited < 10) begin
            tick();
            waited++;
        end
        req_valid[ch] = 1'b0;
        chk("fetch_granted", 256'(granted[ch]), 256'(1));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        req_valid = '0;
        while ((exp_q[0].size() + exp_q[1].size()) != 0 && n < 30) begin
            tick();
            n++;
        end
        chk(name, 256'(exp_q[0].size() + exp_q[1].size()), 256'(0));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        wea       = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_q[c].delete();
            pend[c] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("reset_werr", 256'(werr), 256'(0));
        chk("reset_rsp_data", rsp_data[255:0] | rsp_data[511:256], 256'(0));
        chk("reset_row_sel", 256'(rsp_row_sel), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- test ----------------
    initial begin
        wr_vec_t      wv [7];
        rd_vec_t      rv [4];
        int           waited;
        int           ch0_gnts;
        bit           held_ok;
        logic [255:0] held;
        logic [255:0] exp_blk;
        logic [31:0]  old3;
        logic [31:0]  old6;

        wv[0] = '{WIN_BASE - 27'd4,       32'hB000_0000, 1'b1};
        wv[1] = '{WIN_BASE + 27'h8000,    32'hB000_0001, 1'b1};
        wv[2] = '{WIN_BASE,               32'hB000_0002, 1'b0};
        wv[3] = '{WIN_BASE + 27'h7FFC,    32'hB000_0003, 1'b0};
        wv[4] = '{WIN_BASE + 27'h23,      32'hB000_0004, 1'b0};
        wv[5] = '{27'h0,                  32'hB000_0005, 1'b1};
        wv[6] = '{27'h7FFFFFF,            32'hB000_0006, 1'b1};
        rv[0] = '{0, 0,   0};
        rv[1] = '{1, 0,   2};
        rv[2] = '{0, 127, 15};
        rv[3] = '{1, 127, 14};

        wea = 1'b0; waddr = '0; wdata = '0;
        req_valid = '0; rsp_ready = '1; tex_idx = '0; row_idx = '0;
        for (int i = 0; i < DEPTH*8; i++) model[i] = '0;
        do_reset();

        // Prefill every block that will be read.
        for (int b = 0; b < 64; b++)
            for (int k = 0; k < 8; k++) bus_write(word_addr(b*8 + k), $urandom);
        for (int k = 0; k < 8; k++) bus_write(word_addr(1023*8 + k), $urandom);

        // Basic fetch of a freshly written block, row 1 of texture 0.
        for (int i = 0; i < 8; i++) bus_write(word_addr(i), 32'hA0 + i);
        req_valid = 2'b01;
        set_req(0, 0, 1);
        tick();
        chk("basic_grant", 256'(granted[0]), 256'(1));
        req_valid = '0;
        chk("basic_not_early", 256'(rsp_valid[0]), 256'(0));
        tick();
        chk("basic_valid", 256'(rsp_valid[0]), 256'(1));
        for (int i = 0; i < 8; i++) exp_blk[32*i +: 32] = 32'hA0 + i;
        chk("basic_data", rsp_data[255:0], exp_blk);
        chk("basic_row_sel", 256'(rsp_row_sel[0]), 256'(1));
        drain("basic_drain");

        // Write window table: o_werr pulses exactly one cycle for misses.
        foreach (wv[i]) begin
            bus_write(wv[i].addr, wv[i].data);
            chk("werr_pulse", 256'(werr), 256'(wv[i].exp_werr));
            tick();
            chk("werr_clear", 256'(werr), 256'(0));
        end
        foreach (rv[i]) begin
            run_fetch(rv[i].ch, rv[i].tex, rv[i].row, waited);
            drain("readback_drain");
        end

        // Both channels request continuously: strict alternation from ch0.
        do_reset();
        gnt_log.delete();
        log_en    = 1'b1;
        req_valid = 2'b11;
        set_req(0, $urandom_range(0, 7), $urandom_range(0, 15));
        set_req(1, $urandom_range(0, 7), $urandom_range(0, 15));
        for (int i = 0; i < 20; i++) begin
            tick();
            for (int c = 0; c < NUM_CH; c++)
                if (granted[c]) set_req(c, $urandom_range(0, 7), $urandom_range(0, 15));
        end
        log_en = 1'b0;
        drain("rr_drain");
        chk("rr_grant_count", 256'(gnt_log.size() >= 10), 256'(1));
        foreach (gnt_log[i]) chk("rr_order", 256'(gnt_log[i]), 256'(i % 2));

        // ch1 back-pressures its response; ch0 keeps being served.
        rsp_ready = 2'b01;
        req_valid = 2'b11;
        ch0_gnts  = 0;
        held_ok   = 1'b0;
        held      = '0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (granted[0]) begin
                ch0_gnts++;
                set_req(0, $urandom_range(0, 7), $urandom_range(0, 15));
            end
            if (rsp_valid[1]) begin
                if (held_ok) chk("stall_data_hold", rsp_data[511:256], held);
                held    = rsp_data[511:256];
                held_ok = 1'b1;
                chk("stall_ready_low", 256'(req_ready[1]), 256'(0));
            end
        end
        chk("stall_seen_valid", 256'(held_ok), 256'(1));
        chk("stall_ch0_served", 256'(ch0_gnts >= 3), 256'(1));
        rsp_ready = 2'b11;
        drain("stall_drain");

        // Write to lane 3 of block 18 in the accept cycle.
        old3      = model[18*8 + 3];
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        set_req(0, 2, 4);
        wea = 1'b1; waddr = word_addr(18*8 + 3); wdata = 32'h55;
        tick();
        wea = 1'b0;
        req_valid = '0;
        chk("fwd_acc_grant", 256'(granted[0]), 256'(1));
        tick();
`ifdef TEXMEM_WRITE_FORWARD_EN
        chk("fwd_acc_lane3", 256'(rsp_data[127:96]), 256'(32'h55));
`else
        chk("fwd_acc_lane3", 256'(rsp_data[127:96]), 256'(old3));
`endif
        held = rsp_data[255:0];
        bus_write(word_addr(18*8 + 5), 32'h77);
        chk("rsp_hold_on_write", rsp_data[255:0], held);
        rsp_ready = 2'b11;
        drain("fwd_acc_drain");

        // Write to lane 6 of the same block during the RD cycle.
        old6      = model[18*8 + 6];
        req_valid = 2'b01;
        set_req(0, 2, 5);
        tick();
        req_valid = '0;
        chk("fwd_rd_grant", 256'(granted[0]), 256'(1));
        wea = 1'b1; waddr = word_addr(18*8 + 6); wdata = 32'h66;
        tick();
        wea = 1'b0;
`ifdef TEXMEM_WRITE_FORWARD_EN
        chk("fwd_rd_lane6", 256'(rsp_data[223:192]), 256'(32'h66));
`else
        chk("fwd_rd_lane6", 256'(rsp_data[223:192]), 256'(old6));
`endif
        chk("fwd_rd_row_sel", 256'(rsp_row_sel[0]), 256'(1));
        drain("fwd_rd_drain");

        // Reset asserted while a read is in RD: the response is dropped.
        req_valid = 2'b01;
        set_req(0, 3, 0);
        tick();
        req_valid = '0;
        chk("rst_mid_grant", 256'(granted[0]), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 256'(rsp_valid), 256'(0));
        for (int c = 0; c < NUM_CH; c++) begin
            exp_q[c].delete();
            pend[c] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_mid_quiet", 256'(rsp_valid), 256'(0));
        end
        run_fetch(0, 3, 0, waited);
        chk("rst_post_grant_wait", 256'(waited), 256'(0));
        drain("rst_post_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
